mult_pipe: RTL and testbench

- Parametrised, pipelined integer multiply / multiply-accumulate unit for the execute stage, operating on WIDTH x WIDTH operands.
- Supports a configurable number of pipeline stages and valid/ready flow control in both directions.
- Provides a flush input and MADD/MSUB-style accumulate modes.
- Fully pipelined: one accepted operation per cycle when the output side is not stalled.

---
 rtl/mult_pipe.sv | 171 +++++++++++++++++
 tb/tb_mult_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_pipe.sv
// mult_pipe: pipelined WIDTH x WIDTH multiply / multiply-accumulate unit.
// Operands are extended to WIDTH+1 bits, so one datapath covers both signed and
// unsigned operation. Radix-4 Booth partial products are folded into a
// sum/carry pair with 3:2 carry-save adders. The Booth digits are split evenly
// across the STAGES slots. The last slot also performs the carry-propagate add
// and the accumulate add before its register, so res comes straight from a flop.
module mult_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     src0,
    input  logic [WIDTH-1:0]     src1,
    input  logic                 is_signed,
    input  logic [1:0]           acc_op,
    input  logic [2*WIDTH-1:0]   acc_in,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   res
);

    localparam int PW  = 2 * WIDTH;       // product / accumulator width
    localparam int EW  = WIDTH + 1;       // extended operand width
    localparam int NPP = (WIDTH + 2) / 2; // Booth digits of the extended multiplier

    localparam logic [1:0] OP_MADD = 2'b01;
    localparam logic [1:0] OP_MSUB = 2'b10;

    // Per-slot payload. In the final slot, sum holds the finished result.
    typedef struct packed {
        logic [EW-1:0] a;
        logic [EW-1:0] b;
        logic [1:0]    op;
        logic [PW-1:0] acc;
        logic [PW-1:0] sum;
        logic [PW-1:0] carry;
    } slot_t;

    localparam int SW = $bits(slot_t);

    // One radix-4 Booth partial product for digit j, already shifted into place.
    function automatic logic [PW-1:0] booth_pp(input logic [EW-1:0] a,
                                               input logic [2:0]    dig,
                                               input int            j);
        logic [PW-1:0] a_sx;
        logic [PW-1:0] pp;
        a_sx = {{(PW-EW){a[EW-1]}}, a};
        case (dig)
            3'b001, 3'b010: pp = a_sx;
            3'b011:         pp = a_sx << 1;
            3'b100:         pp = ~(a_sx << 1) + {{(PW-1){1'b0}}, 1'b1};
            3'b101, 3'b110: pp = ~a_sx + {{(PW-1){1'b0}}, 1'b1};
            default:        pp = {PW{1'b0}};
        endcase
        return pp << (2 * j);
    endfunction

    // Fold Booth digits lo..hi-1 into the carry-save pair of a slot.
    function automatic slot_t compress(input slot_t s, input int lo, input int hi);
        slot_t           o;
        logic [EW+1:0]   bx;
        logic [PW-1:0]   pp;
        logic [PW-1:0]   t;
        o  = s;
        // Multiplier sign-extended to an even width, with the implicit b[-1]=0 below it.
        bx = {s.b[EW-1], s.b, 1'b0};
        for (int j = 0; j < NPP; j++) begin
            if (j >= lo && j < hi) begin
                pp      = booth_pp(s.a, bx[2*j +: 3], j);
                t       = o.sum ^ o.carry ^ pp;
                o.carry = ((o.sum & o.carry) | (o.sum & pp) | (o.carry & pp)) << 1;
                o.sum   = t;
            end else begin
                o = o;
            end
        end
        return o;
    endfunction

    // Resolve the carry-save pair and apply the accumulate mode (reserved code acts as MUL).
    function automatic slot_t finalize(input slot_t s);
        slot_t         o;
        logic [PW-1:0] prod;
        o    = s;
        prod = s.sum + s.carry;
        case (s.op)
            OP_MADD: o.sum = s.acc + prod;
            OP_MSUB: o.sum = s.acc - prod;
            default: o.sum = prod;
        endcase
        o.carry = {PW{1'b0}};
        return o;
    endfunction

    slot_t             cap_s;
    slot_t             data_all_s [STAGES];
    logic [STAGES-1:0] vld_all_s;
    logic [STAGES-1:0] adv_s;

    // Operand capture: extend each operand by its sign bit only when signed.
    always_comb begin
        cap_s       = {SW{1'b0}};
        cap_s.a     = {is_signed & src0[WIDTH-1], src0};
        cap_s.b     = {is_signed & src1[WIDTH-1], src1};
        cap_s.op    = acc_op;
        cap_s.acc   = acc_in;
    end

    // Advance chain: a slot may load when it or any slot downstream is empty, or the consumer takes.
    always_comb begin
        logic run;
        run   = out_ready;
        adv_s = {STAGES{1'b0}};
        for (int i = STAGES - 1; i >= 0; i--) begin
            run      = run | ~vld_all_s[i];
            adv_s[i] = run;
        end
    end

    assign in_ready  = rst_n & ~flush & adv_s[0];
    assign out_valid = vld_all_s[STAGES-1];
    assign res       = data_all_s[STAGES-1].sum;

    for (genvar i = 0; i < STAGES; i++) begin : g_slot
        localparam int LO = (i * NPP) / STAGES;
        localparam int HI = ((i + 1) * NPP) / STAGES;

        slot_t src_s;
        slot_t nxt_s;
        logic  vin_s;
        slot_t data_r;
        logic  vld_r;

        if (i == 0) begin : g_head
            assign src_s = cap_s;
            assign vin_s = in_valid & in_ready;
        end else begin : g_body
            assign src_s = data_all_s[i-1];
            assign vin_s = vld_all_s[i-1];
        end

        if (i == STAGES - 1) begin : g_last
            assign nxt_s = finalize(compress(src_s, LO, HI));
        end else begin : g_mid
            assign nxt_s = compress(src_s, LO, HI);
        end

        // Slot register: flush empties it; otherwise it loads whenever allowed to advance.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_r  <= 1'b0;
                data_r <= {SW{1'b0}};
            end else if (flush) begin
                vld_r  <= 1'b0;
            end else if (adv_s[i]) begin
                vld_r <= vin_s;
                if (vin_s) begin
                    data_r <= nxt_s;
                end
            end
        end

        assign vld_all_s[i]  = vld_r;
        assign data_all_s[i] = data_r;
    end

endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench for mult_pipe: directed corner cases, flow control,
// flush and reset, plus a randomized run against an arithmetic reference model.
module tb_mult_pipe;
    localparam int W  = 32;
    localparam int ST = 2;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  src0;
    logic [W-1:0]  src1;
    logic          is_signed;
    logic [1:0]    acc_op;
    logic [PW-1:0] acc_in;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] res;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int pops         = 0;
    int last_lat     = 0;
    logic [PW-1:0] last_res = '0;
    logic          prev_hold = 1'b0;
    logic [PW-1:0] prev_res  = '0;

    typedef struct {
        logic [PW-1:0] val;
        int            acc_cyc;
    } exp_t;
    exp_t sbq[$];

    mult_pipe #(.WIDTH(W), .STAGES(ST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src0      (src0),
        .src1      (src1),
        .is_signed (is_signed),
        .acc_op    (acc_op),
        .acc_in    (acc_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res)
    );

    always #5 clk = ~clk;

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact product in wide arithmetic, reduced modulo 2^(2W).
    function automatic logic [PW-1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic sg, input logic [1:0] op,
                                                input logic [PW-1:0] acc);
        logic [PW-1:0] ax;
        logic [PW-1:0] bx;
        logic [PW-1:0] p;
        ax = sg ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        bx = sg ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        p  = ax * bx;
        case (op)
            2'b01:   return acc + p;
            2'b10:   return acc - p;
            default: return p;
        endcase
    endfunction

    // Scoreboard and monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sbq.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", PW'(out_valid), PW'(1));
                chk("hold_res", res, prev_res);
            end
            if (out_valid && out_ready) begin
                chk("out_expected", PW'(sbq.size() != 0), PW'(1));
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("sb_res", res, e.val);
                    last_lat = cyc - e.acc_cyc;
                    last_res = res;
                    pops++;
                end
            end
            if (flush) begin
                sbq.delete();
            end else if (in_valid && in_ready) begin
                e.val     = ref_model(src0, src1, is_signed, acc_op, acc_in);
                e.acc_cyc = cyc;
                sbq.push_back(e);
            end
            prev_hold = out_valid && !out_ready && !flush;
            prev_res  = res;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                         input logic [1:0] op, input logic [PW-1:0] acc);
        src0 = a; src1 = b; is_signed = sg; acc_op = op; acc_in = acc; in_valid = 1'b1;
    endtask

    task automatic drive_rand();
        drive($urandom, $urandom, 1'($urandom), 2'($urandom), {$urandom, $urandom});
    endtask

    // One operation into an empty pipe; checks value and latency against constants.
    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sg, input logic [1:0] op, input logic [PW-1:0] acc,
                            input logic [PW-1:0] exp);
        int p0;
        int n;
        out_ready = 1'b1;
        drive(a, b, sg, op, acc);
        p0 = pops;
        step();
        in_valid = 1'b0;
        src0 = $urandom; src1 = $urandom; is_signed = ~sg; acc_op = ~op; acc_in = ~acc;
        n = 0;
        while (pops == p0 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_done"}, PW'(pops - p0), PW'(1));
        chk(tag, last_res, exp);
        chk({tag, "_lat"}, PW'(last_lat), PW'(ST));
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return {W{1'b0}};
            1:       return {W{1'b1}};
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {{(W-1){1'b0}}, 1'b1};
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int run;
        int best;
        int accepts;

        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        src0 = '0; src1 = '0; is_signed = 1'b0; acc_op = 2'b00; acc_in = '0;
        #2;
        chk("rst_out_valid", PW'(out_valid), PW'(0));
        chk("rst_res", res, PW'(0));
        chk("rst_in_ready", PW'(in_ready), PW'(0));
        repeat (3) step();
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", PW'(in_ready), PW'(1));

        directed("mul_u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2'b00, 64'h0, 64'hFFFF_FFFE_0000_0001);
        directed("mul_s_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 2'b00, 64'h0, 64'h0000_0000_0000_0001);
        directed("mul_s_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 2'b00, 64'h0, 64'h4000_0000_0000_0000);
        directed("mul_s_min1", 32'h8000_0000, 32'h0000_0001, 1'b1, 2'b00, 64'h0, 64'hFFFF_FFFF_8000_0000);
        directed("madd_u", 32'd3, 32'd4, 1'b0, 2'b01, 64'h5, 64'h11);
        directed("msub_s", 32'd2, 32'd3, 1'b1, 2'b10, 64'h0, 64'hFFFF_FFFF_FFFF_FFFA);
        directed("madd_wrap", 32'd1, 32'd1, 1'b0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        directed("reserved_op", 32'd7, 32'd6, 1'b0, 2'b11, 64'd100, 64'h2A);

        // Back-to-back operations with the consumer always ready.
        out_ready = 1'b1; p0 = pops; run = 0; best = 0;
        for (int i = 0; i < 8 + ST + 2; i++) begin
            if (i < 8) drive_rand(); else in_valid = 1'b0;
            step();
            if (out_valid) run++; else run = 0;
            if (run > best) best = run;
        end
        chk("b2b_run", PW'(best), PW'(8));
        chk("b2b_pops", PW'(pops - p0), PW'(8));

        // Backpressure: only STAGES operations fit while the consumer stalls.
        out_ready = 1'b0; accepts = 0; p0 = pops;
        for (int i = 0; i < 5; i++) begin
            drive_rand();
            if (in_ready) accepts++;
            step();
        end
        chk("bp_accepts", PW'(accepts), PW'(ST));
        chk("bp_in_ready", PW'(in_ready), PW'(0));
        chk("bp_out_valid", PW'(out_valid), PW'(1));
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (ST + 2) step();
        chk("bp_pops", PW'(pops - p0), PW'(ST));
        chk("bp_drained", PW'(sbq.size()), PW'(0));

        // Flush with two operations in flight.
        out_ready = 1'b0;
        drive_rand(); step();
        drive_rand(); step();
        drive_rand(); flush = 1'b1;
        chk("flush_in_ready", PW'(in_ready), PW'(0));
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", PW'(out_valid), PW'(0));
        out_ready = 1'b1; p0 = pops;
        repeat (ST + 2) step();
        chk("flush_no_out", PW'(pops - p0), PW'(0));
        directed("post_flush", 32'h1234_5678, 32'h10, 1'b0, 2'b00, 64'h0, 64'h1_2345_6780);

        // Asynchronous reset while stalled.
        out_ready = 1'b0;
        repeat (3) begin drive_rand(); step(); end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", PW'(out_valid), PW'(0));
        chk("arst_res", res, PW'(0));
        chk("arst_in_ready", PW'(in_ready), PW'(0));
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("arst_release_ready", PW'(in_ready), PW'(1));
        out_ready = 1'b1; p0 = pops;
        repeat (ST + 2) step();
        chk("arst_no_out", PW'(pops - p0), PW'(0));

        // Randomized traffic with random stalls and occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            drive(pick_operand(), pick_operand(), 1'($urandom), 2'($urandom), {$urandom, $urandom});
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (ST + 3) step();
        chk("final_drain", PW'(sbq.size()), PW'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
